mem_port_arbiter: RTL and testbench

//  Shares one single-ported, fixed-latency unified memory between the Mips IF stage (fetch) and MEM stage (load/store).

---
 rtl/mem_port_arbiter.sv | 164 ++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 396 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one fixed-latency single-port memory between IF and MEM
// Serialises fetch and load/store accesses; MEM wins ties, bounded by a starvation streak.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              IF_Req,
  input  logic [ADDR_W-1:0] IF_Addr,
  output logic              IF_Ready,
  output logic [DATA_W-1:0] IF_Rdata,
  output logic              IF_Stall,
  input  logic              MEM_Req,
  input  logic              MEM_We,
  input  logic [ADDR_W-1:0] MEM_Addr,
  input  logic [DATA_W-1:0] MEM_Wdata,
  output logic              MEM_Ready,
  output logic [DATA_W-1:0] MEM_Rdata,
  output logic              MEM_Stall,
  output logic              Mem_En,
  output logic              Mem_We,
  output logic [ADDR_W-1:0] Mem_Addr,
  output logic [DATA_W-1:0] Mem_Wdata,
  input  logic [DATA_W-1:0] Mem_Rdata,
  output logic              Busy
);

  localparam int CNT_W    = $clog2(MEM_LAT + 1);
  localparam int STREAK_W = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]    CNT_INIT   = CNT_W'(MEM_LAT - 1);
  localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(1);
  localparam logic [STREAK_W-1:0] STREAK_TOP = STREAK_W'(STARVE_MAX);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_t;

  state_t              state;
  state_t              next_state;
  logic                owner_mem;
  logic                we_q;
  logic [CNT_W-1:0]    lat_cnt;
  logic [STREAK_W-1:0] streak;
  logic                grant;
  logic                grant_mem;
  logic                done_next;

  // MEM is the older instruction, so it wins unless IF has already waited out a full streak.
  always_comb begin
    next_state = state;
    grant      = 1'b0;
    grant_mem  = 1'b0;
    case (state)
      S_IDLE: begin
        if (IF_Req || MEM_Req) begin
          grant      = 1'b1;
          grant_mem  = MEM_Req && !(IF_Req && (streak == STREAK_TOP));
          next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (we_q) begin
          next_state = S_DONE;
        end else if (MEM_LAT > 1) begin
          next_state = S_WAIT;
        end else begin
          next_state = S_CAPTURE;
        end
      end
      S_WAIT: begin
        if (lat_cnt == CNT_LAST) begin
          next_state = S_CAPTURE;
        end
      end
      S_CAPTURE: next_state = S_DONE;
      S_DONE:    next_state = S_IDLE;
      default:   next_state = S_IDLE;
    endcase
  end

  assign done_next = (next_state == S_DONE);

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      owner_mem <= 1'b0;
      we_q      <= 1'b0;
      lat_cnt   <= '0;
      streak    <= '0;
    end else begin
      if (grant) begin
        owner_mem <= grant_mem;
        we_q      <= grant_mem & MEM_We;
        if (grant_mem && IF_Req) begin
          if (streak != STREAK_TOP) begin
            streak <= streak + 1'b1;
          end
        end else begin
          streak <= '0;
        end
      end
      if (state == S_ISSUE) begin
        lat_cnt <= CNT_INIT;
      end else if (state == S_WAIT) begin
        lat_cnt <= lat_cnt - 1'b1;
      end
    end
  end

  // Request fields are copied at grant so later requester changes cannot disturb the access.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      Mem_En    <= 1'b0;
      Mem_We    <= 1'b0;
      Mem_Addr  <= '0;
      Mem_Wdata <= '0;
    end else begin
      Mem_En <= grant;
      Mem_We <= grant & grant_mem & MEM_We;
      if (grant) begin
        Mem_Addr  <= grant_mem ? MEM_Addr : IF_Addr;
        Mem_Wdata <= grant_mem ? MEM_Wdata : '0;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      IF_Ready  <= 1'b0;
      MEM_Ready <= 1'b0;
      IF_Rdata  <= '0;
      MEM_Rdata <= '0;
    end else begin
      IF_Ready  <= done_next & ~owner_mem;
      MEM_Ready <= done_next & owner_mem;
      if (state == S_CAPTURE) begin
        if (owner_mem) begin
          MEM_Rdata <= Mem_Rdata;
        end else begin
          IF_Rdata <= Mem_Rdata;
        end
      end
    end
  end

  assign IF_Stall  = IF_Req & ~IF_Ready;
  assign MEM_Stall = MEM_Req & ~MEM_Ready;
  assign Busy      = (state != S_IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Directed vectors, hand-written corner sequences, then random traffic against a transaction model.
module tb_mem_port_arbiter;

  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 4;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic              IF_Req;
  logic [ADDR_W-1:0] IF_Addr;
  logic              IF_Ready;
  logic [DATA_W-1:0] IF_Rdata;
  logic              IF_Stall;
  logic              MEM_Req;
  logic              MEM_We;
  logic [ADDR_W-1:0] MEM_Addr;
  logic [DATA_W-1:0] MEM_Wdata;
  logic              MEM_Ready;
  logic [DATA_W-1:0] MEM_Rdata;
  logic              MEM_Stall;
  logic              Mem_En;
  logic              Mem_We;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Wdata;
  logic [DATA_W-1:0] Mem_Rdata;
  logic              Busy;

  mem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_LAT(MEM_LAT), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .IF_Req(IF_Req), .IF_Addr(IF_Addr), .IF_Ready(IF_Ready), .IF_Rdata(IF_Rdata),
    .IF_Stall(IF_Stall),
    .MEM_Req(MEM_Req), .MEM_We(MEM_We), .MEM_Addr(MEM_Addr), .MEM_Wdata(MEM_Wdata),
    .MEM_Ready(MEM_Ready), .MEM_Rdata(MEM_Rdata), .MEM_Stall(MEM_Stall),
    .Mem_En(Mem_En), .Mem_We(Mem_We), .Mem_Addr(Mem_Addr), .Mem_Wdata(Mem_Wdata),
    .Mem_Rdata(Mem_Rdata), .Busy(Busy)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Memory behaviour: loads answer MEM_LAT cycles after the strobe, other cycles carry junk.
  logic [31:0] mem_store [logic [31:0]];
  logic        pend_v [8];
  logic [31:0] pend_d [8];

  initial begin
    for (int i = 0; i < 8; i++) pend_v[i] = 1'b0;
    Mem_Rdata = '0;
    forever begin
      @(posedge Clk);
      #1;
      if (pend_v[cyc % 8]) begin
        Mem_Rdata = pend_d[cyc % 8];
        pend_v[cyc % 8] = 1'b0;
      end else begin
        Mem_Rdata = $urandom;
      end
      if (Mem_En === 1'b1) begin
        if (Mem_We) begin
          mem_store[Mem_Addr] = Mem_Wdata;
        end else begin
          pend_v[(cyc + MEM_LAT) % 8] = 1'b1;
          pend_d[(cyc + MEM_LAT) % 8] = mem_store.exists(Mem_Addr) ? mem_store[Mem_Addr]
                                                                     : init_word(Mem_Addr);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "bench timed out");
  end

  task automatic run_txn(input logic is_mem, input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, output int en_c, output int rdy_c,
                         output int other_rdy, output int stall_bad);
    int   c0;
    logic rdy;
    logic oth;
    logic stl;
    @(posedge Clk);
    #1;
    c0 = cyc;
    en_c = -1;
    rdy_c = -1;
    other_rdy = 0;
    stall_bad = 0;
    if (is_mem) begin
      MEM_Req = 1'b1; MEM_We = we; MEM_Addr = addr; MEM_Wdata = wdata;
    end else begin
      IF_Req = 1'b1; IF_Addr = addr;
    end
    for (int k = 0; k < 20 && rdy_c < 0; k++) begin
      @(negedge Clk);
      rdy = is_mem ? MEM_Ready : IF_Ready;
      oth = is_mem ? IF_Ready : MEM_Ready;
      stl = is_mem ? MEM_Stall : IF_Stall;
      if (Mem_En === 1'b1) begin
        en_c = cyc - c0;
        chk("txn_mem_addr", Mem_Addr, addr);
        chk("txn_mem_we", Mem_We, we);
        if (we) chk("txn_mem_wdata", Mem_Wdata, wdata);
      end
      if (stl !== ~rdy) stall_bad++;
      if (oth !== 1'b0) other_rdy++;
      if (rdy === 1'b1) rdy_c = cyc - c0;
      @(posedge Clk);
      #1;
    end
    IF_Req = 1'b0;
    MEM_Req = 1'b0;
    MEM_We = 1'b0;
    @(negedge Clk);
    chk("txn_busy_after_ready", Busy, 1'b0);
  endtask

  task automatic drain();
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (Busy === 1'b0) break;
    end
    chk("drain_idle", Busy, 1'b0);
  endtask

  typedef struct {
    logic        is_mem;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        pre_en;
    logic [31:0] pre;
    int          exp_lat;
    logic [31:0] exp_if;
    logic [31:0] exp_mem;
  } vec_t;

  vec_t        vecs [7];
  int          en_c, rdy_c, oth_c, stl_c, c0, mrdy, ifen, irdy, stall_lo, ngr, lost, lat_cyc;
  logic        first_m, busy4, busy5;
  logic [9:0]  gmask;
  int          act_g, act_done, streak_m, c;
  logic        act_mem, act_we, e_en, e_ir, e_mr, e_busy;
  logic [31:0] act_addr, act_wdata, act_rd, ref_if, ref_mem;
  logic        if_busy, if_gr, mem_busy, mem_gr;
  logic [31:0] ref_store [logic [31:0]];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,          1'b1, 32'h8C01_0004, 4, 32'h8C01_0004, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF,  1'b0, 32'h0,         2, 32'h8C01_0004, 32'h0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0100, 32'h0,          1'b0, 32'h0,         4, 32'h8C01_0004, 32'hDEAD_BEEF};
    vecs[3] = '{1'b0, 1'b0, 32'h0000_0003, 32'h0,          1'b1, 32'h1234_5678, 4, 32'h1234_5678, 32'hDEAD_BEEF};
    vecs[4] = '{1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0,          1'b1, 32'hA5A5_A5A5, 4, 32'h1234_5678, 32'hA5A5_A5A5};
    vecs[5] = '{1'b1, 1'b1, 32'h0000_0000, 32'h0BAD_F00D,  1'b0, 32'h0,         2, 32'h1234_5678, 32'hA5A5_A5A5};
    vecs[6] = '{1'b0, 1'b0, 32'h0000_0000, 32'h0,          1'b0, 32'h0,         4, 32'h0BAD_F00D, 32'hA5A5_A5A5};

    Reset_n = 1'b0;
    IF_Req = 1'b0; IF_Addr = '0;
    MEM_Req = 1'b0; MEM_We = 1'b0; MEM_Addr = '0; MEM_Wdata = '0;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    chk("rst_mem_en", Mem_En, 1'b0);
    chk("rst_mem_we", Mem_We, 1'b0);
    chk("rst_mem_addr", Mem_Addr, 32'h0);
    chk("rst_if_ready", IF_Ready, 1'b0);
    chk("rst_mem_ready", MEM_Ready, 1'b0);
    chk("rst_if_rdata", IF_Rdata, 32'h0);
    chk("rst_mem_rdata", MEM_Rdata, 32'h0);
    chk("rst_busy", Busy, 1'b0);
    chk("rst_if_stall", IF_Stall, 1'b0);
    chk("rst_mem_stall", MEM_Stall, 1'b0);
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;

    // Single accesses from idle: latency, port values, held data, stall shape.
    for (int v = 0; v < 7; v++) begin
      if (vecs[v].pre_en) mem_store[vecs[v].addr] = vecs[v].pre;
      run_txn(vecs[v].is_mem, vecs[v].we, vecs[v].addr, vecs[v].wdata, en_c, rdy_c, oth_c, stl_c);
      chk("vec_en_cycle", en_c, 1);
      chk("vec_ready_cycle", rdy_c, vecs[v].exp_lat);
      chk("vec_if_rdata", IF_Rdata, vecs[v].exp_if);
      chk("vec_mem_rdata", MEM_Rdata, vecs[v].exp_mem);
      chk("vec_other_ready", oth_c, 0);
      chk("vec_stall_shape", stl_c, 0);
    end

    // Simultaneous requests: MEM first, IF follows after MEM occupancy.
    @(posedge Clk);
    #1;
    c0 = cyc;
    IF_Req = 1'b1; IF_Addr = 32'h200;
    MEM_Req = 1'b1; MEM_We = 1'b0; MEM_Addr = 32'h300;
    mrdy = -1; ifen = -1; irdy = -1; stall_lo = 0; first_m = 1'b0;
    for (int k = 0; k < 20 && irdy < 0; k++) begin
      @(negedge Clk);
      if (IF_Ready !== 1'b1 && IF_Stall !== 1'b1) stall_lo++;
      if (Mem_En === 1'b1 && cyc - c0 == 1) first_m = (Mem_Addr == 32'h300);
      if (MEM_Ready === 1'b1 && mrdy < 0) mrdy = cyc - c0;
      if (Mem_En === 1'b1 && Mem_Addr == 32'h200) ifen = cyc - c0;
      if (IF_Ready === 1'b1) irdy = cyc - c0;
      @(posedge Clk);
      #1;
      if (mrdy >= 0) MEM_Req = 1'b0;
    end
    IF_Req = 1'b0;
    chk("tie_mem_first", first_m, 1'b1);
    chk("tie_mem_ready_cycle", mrdy, 4);
    chk("tie_if_en_cycle", ifen, 6);
    chk("tie_if_ready_cycle", irdy, 9);
    chk("tie_if_stall_held", stall_lo, 0);
    chk("tie_if_rdata", IF_Rdata, init_word(32'h200));
    chk("tie_mem_rdata", MEM_Rdata, init_word(32'h300));

    // Both requesters held high: starvation limit forces IF every STARVE_MAX+1 grants.
    @(posedge Clk);
    #1;
    IF_Req = 1'b1; IF_Addr = 32'h1000;
    MEM_Req = 1'b1; MEM_We = 1'b0; MEM_Addr = 32'h2000;
    gmask = '0; ngr = 0;
    for (int k = 0; k < 120 && ngr < 10; k++) begin
      @(negedge Clk);
      if (Mem_En === 1'b1) begin
        gmask = {gmask[8:0], Mem_Addr == 32'h2000};
        ngr++;
      end
      @(posedge Clk);
      #1;
    end
    IF_Req = 1'b0;
    MEM_Req = 1'b0;
    chk("starve_grant_count", ngr, 10);
    chk("starve_grant_order", gmask, 10'b11110_11110);
    drain();

    // Load whose request drops after grant still completes.
    @(posedge Clk);
    #1;
    c0 = cyc;
    MEM_Req = 1'b1; MEM_We = 1'b0; MEM_Addr = 32'h400;
    mrdy = -1; busy4 = 1'b0; busy5 = 1'b1;
    for (int k = 0; k < 7; k++) begin
      @(negedge Clk);
      if (cyc - c0 == 3) chk("drop_mem_stall_low", MEM_Stall, 1'b0);
      if (cyc - c0 == 4) busy4 = Busy;
      if (cyc - c0 == 5) busy5 = Busy;
      if (MEM_Ready === 1'b1 && mrdy < 0) mrdy = cyc - c0;
      @(posedge Clk);
      #1;
      if (cyc - c0 == 2) MEM_Req = 1'b0;
    end
    chk("drop_ready_cycle", mrdy, 4);
    chk("drop_busy_c4", busy4, 1'b1);
    chk("drop_busy_c5", busy5, 1'b0);
    chk("drop_mem_rdata", MEM_Rdata, init_word(32'h400));

    // Reset asserted while waiting on read data: access is lost silently.
    @(posedge Clk);
    #1;
    IF_Req = 1'b1; IF_Addr = 32'h500;
    @(posedge Clk);
    #1;
    @(posedge Clk);
    #1;
    chk("arst_busy_before", Busy, 1'b1);
    Reset_n = 1'b0;
    #1;
    chk("arst_busy", Busy, 1'b0);
    chk("arst_mem_en", Mem_En, 1'b0);
    chk("arst_if_ready", IF_Ready, 1'b0);
    chk("arst_if_rdata", IF_Rdata, 32'h0);
    chk("arst_mem_rdata", MEM_Rdata, 32'h0);
    IF_Req = 1'b0;
    lost = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge Clk);
      if (IF_Ready !== 1'b0 || MEM_Ready !== 1'b0 || Mem_En !== 1'b0) lost++;
      @(posedge Clk);
      #1;
      if (k == 1) Reset_n = 1'b1;
    end
    chk("arst_no_late_ready", lost, 0);
    run_txn(1'b0, 1'b0, 32'h600, 32'h0, en_c, rdy_c, oth_c, stl_c);
    lat_cyc = rdy_c;
    chk("arst_after_en_cycle", en_c, 1);
    chk("arst_after_ready_cycle", lat_cyc, MEM_LAT + 2);
    chk("arst_after_if_rdata", IF_Rdata, init_word(32'h600));

    // Random traffic against a transaction-level model of the shared port.
    act_g = -1; act_done = -1; streak_m = 0;
    act_mem = 1'b0; act_we = 1'b0; act_addr = '0; act_wdata = '0; act_rd = '0;
    ref_if = init_word(32'h600); ref_mem = 32'h0;
    if_busy = 1'b0; if_gr = 1'b0; mem_busy = 1'b0; mem_gr = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      @(posedge Clk);
      #1;
      c = cyc;
      if (act_done == c - 1) begin
        if (act_mem) mem_busy = 1'b0;
        else if_busy = 1'b0;
      end
      if (!if_busy) begin
        if ($urandom_range(0, 2) == 0) begin
          if_busy = 1'b1; if_gr = 1'b0; IF_Req = 1'b1;
          IF_Addr = 32'h8000 + 32'($urandom_range(0, 63));
        end else begin
          IF_Req = 1'b0;
        end
      end else if (if_gr) begin
        if ($urandom_range(0, 7) == 0) IF_Req = 1'b0;
        if ($urandom_range(0, 3) == 0) IF_Addr = $urandom;
      end
      if (!mem_busy) begin
        if ($urandom_range(0, 1) == 0) begin
          mem_busy = 1'b1; mem_gr = 1'b0; MEM_Req = 1'b1;
          MEM_We = 1'($urandom_range(0, 1));
          MEM_Addr = 32'h8000 + 32'($urandom_range(0, 63));
          MEM_Wdata = $urandom;
        end else begin
          MEM_Req = 1'b0;
        end
      end else if (mem_gr) begin
        if ($urandom_range(0, 7) == 0) MEM_Req = 1'b0;
        if ($urandom_range(0, 3) == 0) begin
          MEM_Addr = $urandom; MEM_Wdata = $urandom; MEM_We = ~MEM_We;
        end
      end

      @(negedge Clk);
      e_en   = (act_g >= 0) && (c == act_g + 1);
      e_ir   = (act_done == c) && !act_mem;
      e_mr   = (act_done == c) && act_mem;
      e_busy = (act_g >= 0) && (c > act_g) && (c <= act_done);
      if (e_ir) ref_if = act_rd;
      if (e_mr && !act_we) ref_mem = act_rd;
      chk("rnd_mem_en", Mem_En, e_en);
      chk("rnd_mem_we", Mem_We, e_en && act_we);
      if (e_en) begin
        chk("rnd_mem_addr", Mem_Addr, act_addr);
        if (act_we) chk("rnd_mem_wdata", Mem_Wdata, act_wdata);
      end
      chk("rnd_if_ready", IF_Ready, e_ir);
      chk("rnd_mem_ready", MEM_Ready, e_mr);
      chk("rnd_busy", Busy, e_busy);
      chk("rnd_if_rdata", IF_Rdata, ref_if);
      chk("rnd_mem_rdata", MEM_Rdata, ref_mem);
      chk("rnd_if_stall", IF_Stall, IF_Req && !e_ir);
      chk("rnd_mem_stall", MEM_Stall, MEM_Req && !e_mr);

      if ((c > act_done) && (IF_Req || MEM_Req)) begin
        act_mem = MEM_Req && !(IF_Req && streak_m == STARVE_MAX);
        if (act_mem && IF_Req) begin
          if (streak_m < STARVE_MAX) streak_m++;
        end else begin
          streak_m = 0;
        end
        act_g     = c;
        act_we    = act_mem ? MEM_We : 1'b0;
        act_addr  = act_mem ? MEM_Addr : IF_Addr;
        act_wdata = MEM_Wdata;
        act_done  = c + (act_we ? 2 : MEM_LAT + 2);
        if (act_we) ref_store[act_addr] = act_wdata;
        else act_rd = ref_store.exists(act_addr) ? ref_store[act_addr] : init_word(act_addr);
        if (act_mem) mem_gr = 1'b1;
        else if_gr = 1'b1;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
